// File: rtl/wave_pkg.sv
// wave_pkg: shared constants and sample-to-duty conversion for the wave DAC family
// Contents: DEF_WIDTH / DEF_PWM_BITS defaults, to_offset_duty() (shift, offset-binary, truncate, trim, saturate)
package wave_pkg;
   localparam int DEF_WIDTH    = 16;
   localparam int DEF_PWM_BITS = 8;
   // Sum is kept two bits wider than the duty so that a negative trim shows up in the MSB
   // and an overflow past full scale shows up in the next bit down.
   function automatic logic [DEF_PWM_BITS-1:0] to_offset_duty(
      input logic [DEF_WIDTH-1:0]    sample,
      input logic [2:0]              gain,
      input logic [DEF_PWM_BITS-1:0] trim
   );
      logic [DEF_WIDTH-1:0]    u;
      logic [DEF_PWM_BITS+1:0] s;
      u = $signed(sample) >>> gain;
      u[DEF_WIDTH-1] = ~u[DEF_WIDTH-1];
      s = {2'b00, u[DEF_WIDTH-1 -: DEF_PWM_BITS]} + {{2{trim[DEF_PWM_BITS-1]}}, trim};
      return s[DEF_PWM_BITS+1] ? '0 : s[DEF_PWM_BITS] ? '1 : s[DEF_PWM_BITS-1:0];
   endfunction
endpackage

// File: rtl/pwm_counter.sv
// pwm_counter: period counter, period-start strobe, enable gating and duty compare
// Ports: clk, rst (sync, active-high), enable, duty_next (duty in effect after this edge),
//        boundary (comb: this edge starts a period), period_start / pwm_out (registered)
module pwm_counter
   import wave_pkg::*;
#(
   parameter int PWM_BITS = DEF_PWM_BITS
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                enable,
   input  logic [PWM_BITS-1:0] duty_next,
   output logic                boundary,
   output logic                period_start,
   output logic                pwm_out
);
   logic [PWM_BITS-1:0] cnt_q, cnt_d;
   logic                run_q, run_d;
   logic                period_start_q, period_start_d;
   logic                pwm_q, pwm_d;
   // run_q remembers that the previous cycle was enabled, so the first enabled cycle
   // after an idle stretch sits at cnt 0 and counts as a period start.
   always_comb begin
      run_d          = enable;
      cnt_d          = (enable && run_q) ? cnt_q + 1'b1 : '0;
      period_start_d = enable && (cnt_d == '0);
      pwm_d          = enable && (cnt_d < duty_next);
      boundary       = period_start_d;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q          <= '0;
         run_q          <= 1'b0;
         period_start_q <= 1'b0;
         pwm_q          <= 1'b0;
      end else begin
         cnt_q          <= cnt_d;
         run_q          <= run_d;
         period_start_q <= period_start_d;
         pwm_q          <= pwm_d;
      end
   end
   assign period_start = period_start_q;
   assign pwm_out      = pwm_q;
endmodule

// File: rtl/wave_pwm_dac.sv
// wave_pwm_dac: 1-bit PWM DAC fed by a valid/ready sample stream, duty updated only at period boundaries
// Ports: clk, rst (sync, active-high), enable, sample_in/sample_valid/sample_ready (handshake),
//        gain (right-shift attenuation), trim (signed duty offset), pwm_out, period_start, duty_q
module wave_pwm_dac
   import wave_pkg::*;
#(
   parameter int WIDTH    = DEF_WIDTH,
   parameter int PWM_BITS = DEF_PWM_BITS
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                enable,
   input  logic [WIDTH-1:0]    sample_in,
   input  logic                sample_valid,
   output logic                sample_ready,
   input  logic [2:0]          gain,
   input  logic [PWM_BITS-1:0] trim,
   output logic                pwm_out,
   output logic                period_start,
   output logic [PWM_BITS-1:0] duty_q
);
   logic [PWM_BITS-1:0] pending_q, pending_d, duty_d;
   logic                pending_full_q, pending_full_d;
   logic                ready_q, ready_d;
   logic                accept, boundary;
   // Accept and a boundary load never coincide: ready is low whenever pending holds a sample.
   always_comb begin
      accept         = sample_valid && ready_q;
      pending_d      = accept ? to_offset_duty(sample_in, gain, trim) : pending_q;
      pending_full_d = accept || (pending_full_q && !boundary);
      duty_d         = (boundary && pending_full_q) ? pending_q : duty_q;
      ready_d        = !pending_full_d;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         pending_q      <= '0;
         pending_full_q <= 1'b0;
         ready_q        <= 1'b0;
         duty_q         <= {1'b1, {(PWM_BITS-1){1'b0}}};
      end else begin
         pending_q      <= pending_d;
         pending_full_q <= pending_full_d;
         ready_q        <= ready_d;
         duty_q         <= duty_d;
      end
   end
   assign sample_ready = ready_q;
   pwm_counter #(.PWM_BITS(PWM_BITS)) u_cnt (
      .clk          (clk),
      .rst          (rst),
      .enable       (enable),
      .duty_next    (duty_d),
      .boundary     (boundary),
      .period_start (period_start),
      .pwm_out      (pwm_out)
   );
endmodule

// File: tb/tb_wave_pwm_dac.sv
// tb_wave_pwm_dac: directed and randomized bench with a cycle-level reference model of the PWM DAC
module tb_wave_pwm_dac;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        enable = 1'b0;
   logic [15:0] sample_in = '0;
   logic        sample_valid = 1'b0;
   logic        sample_ready;
   logic [2:0]  gain = '0;
   logic [7:0]  trim = '0;
   logic        pwm_out;
   logic        period_start;
   logic [7:0]  duty_q;

   int checks = 0;
   int errors = 0;

   int m_k = 0;
   bit m_run = 0;
   int m_duty = 128;
   int pend[$];
   bit m_ready = 0;
   bit m_pwm = 0;
   bit m_ps = 0;

   always #5 clk = ~clk;

   wave_pwm_dac dut (
      .clk          (clk),
      .rst          (rst),
      .enable       (enable),
      .sample_in    (sample_in),
      .sample_valid (sample_valid),
      .sample_ready (sample_ready),
      .gain         (gain),
      .trim         (trim),
      .pwm_out      (pwm_out),
      .period_start (period_start),
      .duty_q       (duty_q)
   );

   // Spec arithmetic on plain integers: shift, add offset, take top 8 bits, add trim, clamp.
   function automatic int conv(logic [15:0] s, logic [2:0] g, logic [7:0] t);
      int sv;
      int d;
      int tr;
      int r;
      sv = $signed(s);
      sv = sv >>> g;
      d  = (sv + 32768) / 256;
      tr = $signed(t);
      r  = d + tr;
      return r < 0 ? 0 : (r > 255 ? 255 : r);
   endfunction

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_edge();
      bit acc;
      if (rst) begin
         m_k = 0; m_run = 0; m_duty = 128; pend.delete();
         m_ready = 0; m_pwm = 0; m_ps = 0;
      end else begin
         acc = sample_valid && m_ready;
         if (enable) begin
            m_k = m_run ? (m_k + 1) % 256 : 0;
            m_run = 1;
         end else begin
            m_k = 0;
            m_run = 0;
         end
         m_ps = enable && (m_k == 0);
         if (m_ps && pend.size() > 0) m_duty = pend.pop_front();
         if (acc) pend.push_back(conv(sample_in, gain, trim));
         m_ready = (pend.size() == 0);
         m_pwm = enable && (m_k < m_duty);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      chk("model_pwm_out", 32'(pwm_out), 32'(m_pwm));
      chk("model_period_start", 32'(period_start), 32'(m_ps));
      chk("model_duty_q", 32'(duty_q), 32'(m_duty));
      chk("model_sample_ready", 32'(sample_ready), 32'(m_ready));
   endtask

   task automatic send(logic [15:0] s, logic [2:0] g, logic [7:0] t);
      bit got;
      got = 0;
      sample_in = s; gain = g; trim = t; sample_valid = 1'b1;
      for (int i = 0; i < 600 && !got; i++) begin
         got = (sample_ready === 1'b1);
         tick();
      end
      sample_valid = 1'b0;
      if (!got) chk("send_timeout", 0, 1);
   endtask

   task automatic wait_start();
      bit got;
      got = 0;
      for (int i = 0; i < 600 && !got; i++) begin
         tick();
         got = (period_start === 1'b1);
      end
      if (!got) chk("wait_start_timeout", 0, 1);
   endtask

   task automatic measure(output int hi);
      hi = 0;
      for (int i = 0; i < 256; i++) begin
         if (i != 0) tick();
         hi += (pwm_out === 1'b1) ? 1 : 0;
      end
   endtask

   initial begin
      int hi;
      int ps;
      tick();
      tick();
      chk("reset_ready", 32'(sample_ready), 0);
      chk("reset_duty", 32'(duty_q), 128);
      chk("reset_pwm", 32'(pwm_out), 0);
      chk("reset_period_start", 32'(period_start), 0);

      rst = 1'b0; enable = 1'b1;
      hi = 0; ps = 0;
      for (int i = 0; i < 512; i++) begin
         tick();
         hi += (pwm_out === 1'b1) ? 1 : 0;
         ps += (period_start === 1'b1) ? 1 : 0;
      end
      chk("idle_high_count", 32'(hi), 256);
      chk("idle_period_starts", 32'(ps), 2);
      chk("idle_duty", 32'(duty_q), 128);
      chk("idle_ready", 32'(sample_ready), 1);

      send(16'h7FFF, 3'd0, 8'h00);
      wait_start();
      chk("max_duty", 32'(duty_q), 255);
      measure(hi);
      chk("max_high_count", 32'(hi), 255);

      send(16'h8000, 3'd0, 8'h00);
      wait_start();
      chk("min_duty", 32'(duty_q), 0);
      measure(hi);
      chk("min_high_count", 32'(hi), 0);

      send(16'h4000, 3'd1, 8'h00);
      wait_start();
      chk("gain1_duty", 32'(duty_q), 160);
      measure(hi);
      chk("gain1_high_count", 32'(hi), 160);

      send(16'h7FFF, 3'd0, 8'd10);
      wait_start();
      chk("trim_pos_sat", 32'(duty_q), 255);
      send(16'h8000, 3'd0, 8'hF6);
      wait_start();
      chk("trim_neg_sat", 32'(duty_q), 0);

      repeat (100) tick();
      sample_in = 16'h4000; gain = 3'd1; trim = 8'h00; sample_valid = 1'b1;
      tick();
      chk("hold_first_ready_drop", 32'(sample_ready), 0);
      chk("hold_duty_before_boundary", 32'(duty_q), 0);
      sample_in = 16'h0000; gain = 3'd0;
      wait_start();
      chk("hold_boundary_duty", 32'(duty_q), 160);
      chk("hold_boundary_ready", 32'(sample_ready), 1);
      tick();
      sample_valid = 1'b0;
      chk("hold_second_accept", 32'(sample_ready), 0);
      chk("hold_duty_kept", 32'(duty_q), 160);
      wait_start();
      chk("hold_second_duty", 32'(duty_q), 128);

      repeat (30) tick();
      send(16'h7FFF, 3'd0, 8'h00);
      chk("pend_full_ready", 32'(sample_ready), 0);
      rst = 1'b1;
      tick();
      chk("midreset_duty", 32'(duty_q), 128);
      chk("midreset_ready", 32'(sample_ready), 0);
      rst = 1'b0;
      tick();
      chk("postreset_ready", 32'(sample_ready), 1);
      chk("postreset_start", 32'(period_start), 1);
      repeat (300) tick();
      chk("postreset_pending_dropped", 32'(duty_q), 128);

      repeat (50) tick();
      enable = 1'b0;
      tick();
      chk("disable_pwm", 32'(pwm_out), 0);
      chk("disable_period_start", 32'(period_start), 0);
      send(16'h7FFF, 3'd0, 8'h00);
      chk("disable_pwm_held", 32'(pwm_out), 0);
      chk("disable_duty_held", 32'(duty_q), 128);
      enable = 1'b1;
      tick();
      chk("reenable_start", 32'(period_start), 1);
      chk("reenable_load", 32'(duty_q), 255);
      chk("reenable_pwm", 32'(pwm_out), 1);

      for (int i = 0; i < 4000; i++) begin
         rst          = ($urandom % 400) == 0;
         enable       = ($urandom % 20) != 0;
         sample_valid = ($urandom % 4) == 0;
         sample_in    = 16'($urandom);
         gain         = 3'($urandom);
         trim         = 8'($urandom);
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
